// File: rtl/text_banner.sv
// text_banner: writable-buffer text overlay rendered with a scaled 5x7 font.
// Ports: clk/rst (async active-high), x/y pixel coordinate, en overlay enable,
// frame_tick per-frame pulse, start latches mode/len and restarts the phase,
// wr_en/wr_addr/wr_char buffer write port, disp registered lit flag, done reveal finished.
module text_banner #(
  parameter int MAX_CHARS     = 8,
  parameter int SCALE         = 4,
  parameter int PITCH         = 40,
  parameter int X0            = 304,
  parameter int Y0            = 280,
  parameter int BLINK_FRAMES  = 30,
  parameter int REVEAL_FRAMES = 8,
  localparam int LW = $clog2(MAX_CHARS + 1),
  localparam int AW = MAX_CHARS > 1 ? $clog2(MAX_CHARS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          en,
  input  logic          frame_tick,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [LW-1:0] len,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [4:0]    wr_char,
  output logic          disp,
  output logic          done
);
  localparam int SH   = $clog2(SCALE);
  localparam int FMAX = BLINK_FRAMES > REVEAL_FRAMES ? BLINK_FRAMES : REVEAL_FRAMES;
  localparam int FW   = $clog2(FMAX + 1);
  localparam logic [1:0] M_BLINK  = 2'd1;
  localparam logic [1:0] M_REVEAL = 2'd2;

  logic [4:0]    chars [MAX_CHARS];
  logic [1:0]    mode_q;
  logic [LW-1:0] len_q, rcnt, len_sat, shown, ci;
  logic [FW-1:0] fcnt;
  logic          vis, hit, yin, lit;
  logic [4:0]    code, rbits;
  logic [2:0]    col, row;
  logic [34:0]   g;
  logic [15:0]   xw, yw;

  // Seven 5-bit rows, top row in the MSBs, bit 4 of each row is the leftmost dot.
  function automatic logic [34:0] font(input logic [4:0] c);
    case (c)
      5'd1:  return 35'b01110_10001_10001_11111_10001_10001_10001;
      5'd2:  return 35'b11110_10001_10001_11110_10001_10001_11110;
      5'd3:  return 35'b01110_10001_10000_10000_10000_10001_01110;
      5'd4:  return 35'b11100_10010_10001_10001_10001_10010_11100;
      5'd5:  return 35'b11111_10000_10000_11110_10000_10000_11111;
      5'd6:  return 35'b11111_10000_10000_11110_10000_10000_10000;
      5'd7:  return 35'b01110_10001_10000_10111_10001_10001_01111;
      5'd8:  return 35'b10001_10001_10001_11111_10001_10001_10001;
      5'd9:  return 35'b01110_00100_00100_00100_00100_00100_01110;
      5'd10: return 35'b00111_00010_00010_00010_00010_10010_01100;
      5'd11: return 35'b10001_10010_10100_11000_10100_10010_10001;
      5'd12: return 35'b10000_10000_10000_10000_10000_10000_11111;
      5'd13: return 35'b10001_11011_10101_10101_10001_10001_10001;
      5'd14: return 35'b10001_10001_11001_10101_10011_10001_10001;
      5'd15: return 35'b01110_10001_10001_10001_10001_10001_01110;
      5'd16: return 35'b11110_10001_10001_11110_10000_10000_10000;
      5'd17: return 35'b01110_10001_10001_10001_10101_10010_01101;
      5'd18: return 35'b11110_10001_10001_11110_10100_10010_10001;
      5'd19: return 35'b01111_10000_10000_01110_00001_00001_11110;
      5'd20: return 35'b11111_00100_00100_00100_00100_00100_00100;
      5'd21: return 35'b10001_10001_10001_10001_10001_10001_01110;
      5'd22: return 35'b10001_10001_10001_10001_10001_01010_00100;
      5'd23: return 35'b10001_10001_10001_10101_10101_10101_01010;
      5'd24: return 35'b10001_10001_01010_00100_01010_10001_10001;
      5'd25: return 35'b10001_10001_01010_00100_00100_00100_00100;
      5'd26: return 35'b11111_00001_00010_00100_01000_10000_11111;
      5'd27: return 35'b00100_00100_00100_00100_00100_00000_00100;
      5'd28: return 35'b01110_10001_00001_00010_00100_00000_00100;
      5'd29: return 35'b00000_01100_01100_00000_01100_01100_00000;
      5'd30: return 35'b00000_00000_00000_11111_00000_00000_00000;
      default: return 35'd0;
    endcase
  endfunction

  // Cells never overlap (PITCH >= 5*SCALE), so at most one cell matches; the
  // 16-bit compare keeps cells near the right edge of the screen from wrapping.
  always_comb begin
    xw = 16'(x);
    yw = 16'(y);
    hit = 1'b0;
    code = '0;
    ci = '0;
    col = '0;
    for (int i = 0; i < MAX_CHARS; i++)
      if (xw >= 16'(X0 + i*PITCH) && xw < 16'(X0 + i*PITCH + 5*SCALE)) begin
        hit = 1'b1;
        code = chars[i];
        ci = LW'(i);
        col = 3'((xw - 16'(X0 + i*PITCH)) >> SH);
      end
    yin = yw >= 16'(Y0) && yw < 16'(Y0 + 7*SCALE);
    row = yin ? 3'((yw - 16'(Y0)) >> SH) : 3'd0;
    g = font(code);
    rbits = g[5*(6 - int'(row)) +: 5];
    shown = mode_q == M_REVEAL ? rcnt : len_q;
    lit = en && vis && hit && yin && ci < shown && rbits[3'd4 - col];
    len_sat = len > LW'(MAX_CHARS) ? LW'(MAX_CHARS) : len;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < MAX_CHARS; i++) chars[i] <= '0;
      disp <= 1'b0;
    end else begin
      if (wr_en && {1'b0, wr_addr} < (AW+1)'(MAX_CHARS)) chars[wr_addr] <= wr_char;
      disp <= lit;
    end

  // start has priority over a coincident frame_tick, which is dropped.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mode_q <= '0;
      len_q <= '0;
      fcnt <= '0;
      rcnt <= '0;
      vis <= 1'b1;
      done <= 1'b0;
    end else if (start) begin
      mode_q <= mode;
      len_q <= len_sat;
      fcnt <= '0;
      rcnt <= '0;
      vis <= 1'b1;
      done <= mode != M_REVEAL || len == '0;
    end else begin
      if (frame_tick && mode_q == M_BLINK) begin
        fcnt <= fcnt == FW'(BLINK_FRAMES - 1) ? '0 : fcnt + 1'b1;
        if (fcnt == FW'(BLINK_FRAMES - 1)) vis <= ~vis;
      end
      if (frame_tick && mode_q == M_REVEAL && rcnt < len_q) begin
        fcnt <= fcnt == FW'(REVEAL_FRAMES - 1) ? '0 : fcnt + 1'b1;
        if (fcnt == FW'(REVEAL_FRAMES - 1)) rcnt <= rcnt + 1'b1;
      end
      if (mode_q == M_REVEAL) done <= rcnt == len_q;
    end
endmodule

// File: tb/tb_text_banner.sv
// tb_text_banner: directed self-checking bench for text_banner.
module tb_text_banner;
  logic       clk = 1'b0, rst = 1'b1, en = 1'b1, frame_tick = 1'b0, start = 1'b0, wr_en = 1'b0;
  logic [9:0] x = '0, y = '0;
  logic [1:0] mode = '0;
  logic [3:0] len = '0;
  logic [2:0] wr_addr = '0;
  logic [4:0] wr_char = '0;
  logic       disp, done;
  int n_checks = 0, n_fail = 0;

  text_banner dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .en(en), .frame_tick(frame_tick),
    .start(start), .mode(mode), .len(len), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_char(wr_char), .disp(disp), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int px, input int py);
    x = 10'(px);
    y = 10'(py);
    cyc();
  endtask

  task automatic wr(input int a, input int c);
    wr_en = 1'b1;
    wr_addr = 3'(a);
    wr_char = 5'(c);
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic go(input int m, input int l);
    mode = 2'(m);
    len = 4'(l);
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
    end
  endtask

  initial begin
    cyc();
    check("rst_disp", disp, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    cyc();
    // static "PAUSE"
    wr(0, 16); wr(1, 1); wr(2, 21); wr(3, 19); wr(4, 5);
    go(0, 5);
    probe(304, 280); check("st_origin", disp, 1);
    probe(320, 280); check("st_p_col4", disp, 0);
    probe(303, 280); check("st_left", disp, 0);
    probe(308, 280); check("st_p_col1", disp, 1);
    probe(344, 284); check("st_a_row1", disp, 1);
    probe(504, 280); check("st_beyond_len", disp, 0);
    probe(304, 308); check("st_below", disp, 0);
    check("st_done", done, 1);
    // blink
    go(1, 5);
    probe(304, 280); check("bl_t0", disp, 1);
    ticks(10);
    en = 1'b0; cyc(); check("bl_en_off", disp, 0);
    ticks(10);
    en = 1'b1; cyc(); check("bl_en_on", disp, 1);
    ticks(9); check("bl_t29", disp, 1);
    ticks(1); check("bl_t30", disp, 0);
    ticks(29); check("bl_t59", disp, 0);
    ticks(1); check("bl_t60", disp, 1);
    check("bl_done", done, 1);
    // reveal
    go(2, 5);
    probe(304, 280); check("rv_init_disp", disp, 0);
    check("rv_init_done", done, 0);
    ticks(7); check("rv_t7", disp, 0);
    ticks(1); check("rv_t8", disp, 1);
    probe(344, 284); check("rv_t8_char1", disp, 0);
    ticks(31); check("rv_t39_done", done, 0);
    ticks(1); check("rv_t40_done", done, 1);
    probe(464, 280); check("rv_t40_char4", disp, 1);
    ticks(1); check("rv_t41_rcnt", dut.rcnt, 5);
    check("rv_t41_done", done, 1);
    // saturation and start/tick collision
    wr(7, 16);
    go(0, 12);
    check("sat_len_q", dut.len_q, 8);
    probe(584, 280); check("sat_idx7", disp, 1);
    probe(624, 280); check("sat_idx8", disp, 0);
    go(1, 5);
    ticks(3); check("col_pre_fcnt", dut.fcnt, 3);
    mode = 2'd2; start = 1'b1; frame_tick = 1'b1;
    cyc();
    start = 1'b0; frame_tick = 1'b0;
    check("col_fcnt", dut.fcnt, 0);
    check("col_rcnt", dut.rcnt, 0);
    // reset mid-reveal, then write during render
    go(2, 5);
    ticks(20);
    probe(304, 280); check("rs_pre_disp", disp, 1);
    rst = 1'b1; #1;
    check("rs_disp", disp, 0);
    check("rs_done", done, 0);
    cyc();
    rst = 1'b0;
    cyc();
    go(0, 5);
    probe(304, 280); check("rs_blank", disp, 0);
    x = 10'd304; y = 10'd284;
    wr(0, 1); check("wr_old", disp, 0);
    cyc(); check("wr_new", disp, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
